// File: rtl/net_inference_sequencer.sv
// Purpose : frame-level scheduler for the streaming FNN: gathers one pixel frame, then starts each layer stage in turn.
// Latency : last accepted pixel -> layer_start[0] 1 cycle; done[k] -> start[k+1] 1 cycle; done[NS-1] -> result_valid 1 cycle.
// Backpr. : pix_ready only in STREAM; result_valid held until result_ready; a WAIT holds until the awaited stage reports done.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   frame_start           inference request (level, sampled in IDLE or on a RESULT handshake)
//   pix_valid / pix_ready pixel beat handshake; beat = pix_valid & pix_ready
//   stream_freeze         hold pixel-stream block and stage-0 layer (everywhere except STREAM)
//   stream_pause          STREAM cycle with no beat
//   layer_start[NS]       one-hot single-cycle start to the current stage
//   layer_done[NS]        stage completion; only the awaited bit is looked at
//   stage_idx             stage currently being started / waited on
//   pix_count             beats accepted in the current frame
//   busy                  inference in progress
//   result_valid / result_ready  result handshake
//   err                   watchdog fired (sticky until next accepted frame_start)
//
// Optional feature macro: NET_SEQ_WATCHDOG_EN (per-stage watchdog of WD_LIMIT cycles).
module net_inference_sequencer #(
  parameter int  NUM_LAYERS = 3,
  parameter int  IN_COUNT   = 16,
  parameter int  CNT_W      = 16,
  parameter int  WD_LIMIT   = 1024,
  localparam int NS         = NUM_LAYERS - 1,
  localparam int SI_W       = $clog2(NS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             stream_freeze,
  output logic             stream_pause,
  output logic [NS-1:0]    layer_start,
  input  logic [NS-1:0]    layer_done,
  output logic [SI_W-1:0]  stage_idx,
  output logic [CNT_W-1:0] pix_count,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             err
);

  if (IN_COUNT < 1 || NS < 1 || WD_LIMIT < 1 || ((IN_COUNT - 1) >> CNT_W) != 0) begin : g_bad_param
    $error("net_inference_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_count_nxt;
  logic [SI_W-1:0]  stage_idx_nxt;
  logic             done_sel;
  logic             beat;
  logic             frame_acc;
  logic             wd_expire;

  // A new frame is accepted from IDLE, or straight out of RESULT when the
  // consumer takes the result in the same cycle (back-to-back inference).
  assign frame_acc = frame_start &
                     ((state == S_IDLE) | ((state == S_RESULT) & result_ready));
  assign beat      = pix_valid & (state == S_STREAM);

`ifdef NET_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // wd_cnt counts completed WAIT cycles; expiry on the WD_LIMIT-th one.
  assign wd_expire = (state == S_WAIT) & ~done_sel & (wd_cnt == WD_W'(WD_LIMIT - 1));
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      // WAIT is only ever entered from START, so clearing here clears on entry.
      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (frame_acc)            err_q  <= 1'b0;
      else if (wd_expire)       err_q  <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pix_count <= '0;
      stage_idx <= '0;
    end else begin
      state     <= state_nxt;
      pix_count <= pix_count_nxt;
      stage_idx <= stage_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pix_count_nxt = pix_count;
    stage_idx_nxt = stage_idx;
    done_sel      = 1'b0;
    pix_ready     = 1'b0;
    stream_freeze = 1'b1;
    busy          = 1'b1;
    result_valid  = 1'b0;
    layer_start   = '0;

    // Mux out only the awaited done bit; a loop avoids an over-wide index.
    for (int k = 0; k < NS; k++) begin
      if (stage_idx == SI_W'(k)) done_sel = layer_done[k];
    end

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_acc) begin
          state_nxt     = S_STREAM;
          pix_count_nxt = '0;
        end
      end
      S_STREAM: begin
        pix_ready     = 1'b1;
        stream_freeze = 1'b0;
        if (beat) begin
          pix_count_nxt = pix_count + 1'b1;
          if (pix_count == CNT_W'(IN_COUNT - 1)) begin
            state_nxt     = S_START;
            stage_idx_nxt = '0;
          end
        end
      end
      S_START: begin
        for (int k = 0; k < NS; k++) begin
          layer_start[k] = (stage_idx == SI_W'(k));
        end
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          if (stage_idx == SI_W'(NS - 1)) begin
            state_nxt = S_RESULT;
          end else begin
            state_nxt     = S_START;
            stage_idx_nxt = stage_idx + 1'b1;
          end
        end else if (wd_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESULT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          if (frame_acc) begin
            state_nxt     = S_STREAM;
            pix_count_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Only non-Moore output: a STREAM cycle without a beat stalls the MACs.
  assign stream_pause = (state == S_STREAM) & ~pix_valid;

endmodule

// File: tb/tb_net_inference_sequencer.sv
module tb_net_inference_sequencer;

  localparam int NUM_LAYERS = 3;
  localparam int IN_COUNT   = 16;
  localparam int CNT_W      = 16;
  localparam int WD_LIMIT   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        stream_freeze;
  logic        stream_pause;
  logic [1:0]  layer_start;
  logic [1:0]  layer_done = 2'b00;
  logic [1:0]  stage_idx;
  logic [15:0] pix_count;
  logic        busy;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  net_inference_sequencer #(
    .NUM_LAYERS (NUM_LAYERS),
    .IN_COUNT   (IN_COUNT),
    .CNT_W      (CNT_W),
    .WD_LIMIT   (WD_LIMIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .stream_freeze (stream_freeze),
    .stream_pause  (stream_pause),
    .layer_start   (layer_start),
    .layer_done    (layer_done),
    .stage_idx     (stage_idx),
    .pix_count     (pix_count),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a frame from IDLE and feed IN_COUNT contiguous beats; ends in START.
  task automatic run_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    for (int i = 0; i < IN_COUNT; i++) step();
    pix_valid = 1'b0;
  endtask

  // {pix_ready, stream_freeze, stream_pause, layer_start, busy, result_valid, err, stage_idx, pix_count}
  function automatic logic [25:0] snap();
    return {pix_ready, stream_freeze, stream_pause, layer_start, busy, result_valid, err, stage_idx, pix_count};
  endfunction

  task automatic test_reset();
    logic [25:0] exp_rst;
    exp_rst = {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (snap() !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", snap(), exp_rst);
    end
    rst_n = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_cmp++;
    if (pix_count !== 16'd7 || pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_count: got count=%0d ready=%b expected count=7 ready=1", pix_count, pix_ready);
    end
    rst_n = 1'b0;
    step();
    // pix_valid is still high here; in IDLE stream_pause must stay 0 regardless.
    n_cmp++;
    if (snap() !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_mid_stream: got %h expected %h", snap(), exp_rst);
    end
    pix_valid = 1'b0;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_cmp++;
    if ({pix_ready, stream_freeze, busy, pix_count} !== {1'b1, 1'b0, 1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL nom_stream_entry: got rdy=%b frz=%b busy=%b cnt=%0d expected 1 0 1 0",
               pix_ready, stream_freeze, busy, pix_count);
    end
    pix_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (layer_start !== 2'b00 || pix_count !== 16'(i + 1) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL nom_beat%0d: got start=%b cnt=%0d busy=%b expected 00 %0d 1",
                 i, layer_start, pix_count, busy, i + 1);
      end
    end
    step();
    pix_valid = 1'b0;
    n_cmp++;
    if ({layer_start, stage_idx, pix_count, stream_freeze, pix_ready, busy} !==
        {2'b01, 2'd0, 16'd16, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL nom_start0: got start=%b idx=%0d cnt=%0d frz=%b rdy=%b busy=%b expected 01 0 16 1 0 1",
               layer_start, stage_idx, pix_count, stream_freeze, pix_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (layer_start !== 2'b00 || busy !== 1'b1 || stage_idx !== 2'd0) begin
        n_fail++;
        $display("FAIL nom_wait0_%0d: got start=%b busy=%b idx=%0d expected 00 1 0", i, layer_start, busy, stage_idx);
      end
    end
    step();
    layer_done = 2'b01;
    step();
    layer_done = 2'b00;
    n_cmp++;
    if (layer_start !== 2'b10 || stage_idx !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_start1: got start=%b idx=%0d busy=%b expected 10 1 1", layer_start, stage_idx, busy);
    end
    step();
    step();
    layer_done = 2'b10;
    step();
    layer_done = 2'b00;
    n_cmp++;
    if (result_valid !== 1'b1 || busy !== 1'b1 || layer_start !== 2'b00) begin
      n_fail++;
      $display("FAIL nom_result: got valid=%b busy=%b start=%b expected 1 1 00", result_valid, busy, layer_start);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || stream_freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_idle: got valid=%b busy=%b frz=%b expected 0 0 1", result_valid, busy, stream_freeze);
    end
  endtask

  task automatic test_gaps();
    int beats;
    int cyc;
    logic pv;
    beats = 0;
    cyc   = 0;
    frame_start = 1'b1;
    step();
    // frame_start stays high through STREAM; it must have no effect there.
    while (beats < IN_COUNT && cyc < 100) begin
      pv = (cyc % 3 == 0);
      pix_valid = pv;
      #1;
      n_cmp++;
      if (stream_pause !== !pv || pix_count !== 16'(beats) || pix_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_cyc%0d: got pause=%b cnt=%0d rdy=%b expected %b %0d 1",
                 cyc, stream_pause, pix_count, pix_ready, !pv, beats);
      end
      step();
      if (pv) beats++;
      cyc++;
    end
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    n_cmp++;
    if (layer_start !== 2'b01 || pix_count !== 16'd16 || cyc !== 46) begin
      n_fail++;
      $display("FAIL gap_done: got start=%b cnt=%0d cycles=%0d expected 01 16 46", layer_start, pix_count, cyc);
    end
    step();
    layer_done = 2'b01;
    step();
    step();
    layer_done = 2'b10;
    step();
    layer_done   = 2'b00;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_stray_done();
    run_frame();
    // In START now; done[0] asserted this very cycle must not count.
    layer_done = 2'b01;
    step();
    layer_done = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (layer_start !== 2'b00 || stage_idx !== 2'd0 || result_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stray_%0d: got start=%b idx=%0d valid=%b busy=%b expected 00 0 0 1",
                 i, layer_start, stage_idx, result_valid, busy);
      end
    end
    layer_done = 2'b01;
    step();
    layer_done = 2'b00;
    n_cmp++;
    if (layer_start !== 2'b10 || stage_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL stray_start1: got start=%b idx=%0d expected 10 1", layer_start, stage_idx);
    end
    step();
    layer_done = 2'b10;
    step();
    layer_done = 2'b00;
    n_cmp++;
    if (result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_result: got valid=%b expected 1", result_valid);
    end
  endtask

  task automatic test_back_to_back();
    // Enters in RESULT from test_stray_done.
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (result_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_hold%0d: got valid=%b busy=%b expected 1 1", i, result_valid, busy);
      end
    end
    result_ready = 1'b1;
    frame_start  = 1'b1;
    step();
    result_ready = 1'b0;
    frame_start  = 1'b0;
    n_cmp++;
    if ({pix_ready, pix_count, result_valid, busy, stream_freeze} !== {1'b1, 16'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_stream: got rdy=%b cnt=%0d valid=%b busy=%b frz=%b expected 1 0 0 1 0",
               pix_ready, pix_count, result_valid, busy, stream_freeze);
    end
    pix_valid = 1'b1;
    for (int i = 0; i < IN_COUNT; i++) step();
    pix_valid = 1'b0;
    n_cmp++;
    if (layer_start !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_start0: got start=%b expected 01", layer_start);
    end
  endtask

  task automatic test_watchdog();
    // Enters in START of stage 0; done is never given.
    step();
`ifdef NET_SEQ_WATCHDOG_EN
    for (int i = 0; i < WD_LIMIT - 1; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL wd_pre%0d: got busy=%b err=%b expected 1 0", i, busy, err);
      end
    end
    step();
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || stream_freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_fire: got err=%b busy=%b valid=%b frz=%b expected 1 0 0 1",
               err, busy, result_valid, stream_freeze);
    end
    step();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: got err=%b expected 1", err);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_clear: got err=%b rdy=%b expected 0 1", err, pix_ready);
    end
`else
    for (int i = 0; i < 1000; i++) step();
    n_cmp++;
    if ({busy, layer_start, result_valid, err, stage_idx} !== {1'b1, 2'b00, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL wd_off_hold: got busy=%b start=%b valid=%b err=%b idx=%0d expected 1 00 0 0 0",
               busy, layer_start, result_valid, err, stage_idx);
    end
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_reset: got busy=%b err=%b expected 0 0", busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gaps();
    test_stray_done();
    test_back_to_back();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
